// File: rtl/regfile_sb.sv
// Three-port register file (2 async reads, 1 clocked write) with per-register busy
// scoreboard and pending-write counter. Optional macro REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   wa3,
  input  logic [XLEN-1:0] wd3,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_pend_cnt;

  logic             w_wr_en;
  logic             w_iss_en;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_busy_nxt;

  // Issue wins over writeback on the same register, so that case never decrements.
  always_comb begin
    w_wr_en    = we3 && (wa3 != '0);
    w_iss_en   = iss_valid && (iss_rd != '0);
    w_inc      = w_iss_en && !r_busy[iss_rd];
    w_dec      = w_wr_en && r_busy[wa3] && !(w_iss_en && (iss_rd == wa3));
    w_busy_nxt = r_busy;
    if (w_wr_en)  w_busy_nxt[wa3]    = 1'b0;
    if (w_iss_en) w_busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr_en) r_rf[wa3] <= wd3;
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= r_pend_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  always_comb begin
    rd1   = (ra1 == '0) ? '0 : r_rf[ra1];
    rd2   = (ra2 == '0) ? '0 : r_rf[ra2];
    busy1 = r_busy[ra1];
    busy2 = r_busy[ra2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (wa3 == ra1)) begin
      rd1   = wd3;
      busy1 = 1'b0;
    end
    if (w_wr_en && (wa3 == ra2)) begin
      rd2   = wd3;
      busy2 = 1'b0;
    end
`endif
  end

  assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a behavioural model predicts read ports and
// pending count; directed cases plus a random phase.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [AW-1:0]   ra1 = '0, ra2 = '0;
  logic [XLEN-1:0] rd1, rd2;
  logic            busy1, busy2;
  logic            we3 = 1'b0;
  logic [AW-1:0]   wa3 = '0;
  logic [XLEN-1:0] wd3 = '0;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_rd = '0;
  logic [AW:0]     pend_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .pend_cnt(pend_cnt)
  );

  typedef struct {
    string           tag;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            b1;
    logic            b2;
    logic [AW:0]     cnt;
  } exp_t;

  exp_t             sb[$];
  logic [XLEN-1:0]  m_rf [NREGS];
  logic [NREGS-1:0] m_busy;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out(input string tag);
    exp_t e;
    e.tag = tag;
    e.rd1 = (ra1 == 0) ? '0 : m_rf[ra1];
    e.rd2 = (ra2 == 0) ? '0 : m_rf[ra2];
    e.b1  = m_busy[ra1];
    e.b2  = m_busy[ra2];
    e.cnt = (AW+1)'($countones(m_busy));
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 != 0 && wa3 == ra1) begin e.rd1 = wd3; e.b1 = 1'b0; end
    if (we3 && wa3 != 0 && wa3 == ra2) begin e.rd2 = wd3; e.b2 = 1'b0; end
`endif
    return e;
  endfunction

  // Push the prediction at drive time, pop and compare once outputs settle.
  task automatic sample(input string tag);
    exp_t e;
    sb.push_back(model_out(tag));
    #1;
    e = sb.pop_front();
    check({e.tag, ".rd1"}, rd1, e.rd1);
    check({e.tag, ".rd2"}, rd2, e.rd2);
    check({e.tag, ".busy1"}, busy1, e.b1);
    check({e.tag, ".busy2"}, busy2, e.b2);
    check({e.tag, ".pend_cnt"}, pend_cnt, e.cnt);
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, then idle the controls.
  task automatic clock_edge;
    logic            c_rst = reset, c_we = we3, c_iv = iss_valid;
    logic [AW-1:0]   c_wa = wa3, c_ir = iss_rd;
    logic [XLEN-1:0] c_wd = wd3;
    @(posedge clk);
    if (c_rst) begin
      for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
      m_busy = '0;
    end else begin
      if (c_we && c_wa != 0) begin m_rf[c_wa] = c_wd; m_busy[c_wa] = 1'b0; end
      if (c_iv && c_ir != 0) m_busy[c_ir] = 1'b1;
    end
    #1;
    reset = 1'b0; we3 = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [XLEN-1:0] d);
    we3 = 1'b1; wa3 = AW'(a); wd3 = d;
    clock_edge();
  endtask

  task automatic do_issue(input int a);
    iss_valid = 1'b1; iss_rd = AW'(a);
    clock_edge();
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_busy = '0;
    #2;
    reset = 1'b1; clock_edge();
    reset = 1'b1; clock_edge();

    // Random writes and issues, then reset clears everything.
    for (int i = 0; i < 20; i++) begin
      we3 = 1'b1; wa3 = AW'($urandom_range(0, NREGS-1)); wd3 = $urandom;
      iss_valid = 1'b1; iss_rd = AW'($urandom_range(0, NREGS-1));
      clock_edge();
    end
    reset = 1'b1; clock_edge();
    for (int i = 0; i < NREGS/2; i++) begin
      ra1 = AW'(i); ra2 = AW'(NREGS-1-i);
      sample("post_reset");
      check("post_reset.rd1_zero", rd1, 0);
      check("post_reset.rd2_zero", rd2, 0);
    end
    check("post_reset.cnt_zero", pend_cnt, 0);

    // Register 0 ignores writes; register 5 shows data the next cycle.
    do_write(0, 32'hDEADBEEF);
    ra1 = '0; sample("r0_write");
    check("r0_write.rd1", rd1, 0);
    do_write(5, 32'hDEADBEEF);
    ra2 = AW'(5); sample("r5_write");
    check("r5_write.rd2", rd2, 32'hDEADBEEF);

    // Issue r3, r7; then writeback r3.
    do_issue(3);
    do_issue(7);
    ra1 = AW'(3); sample("issue37");
    check("issue37.cnt", pend_cnt, 2);
    check("issue37.busy1", busy1, 1);
    do_write(3, 32'h1234);
    sample("wb3");
    check("wb3.cnt", pend_cnt, 1);
    check("wb3.busy1", busy1, 0);
    check("wb3.rd1", rd1, 32'h1234);

    // Issue on r0 ignored.
    do_issue(0);
    ra1 = '0; sample("iss_r0");
    check("iss_r0.cnt", pend_cnt, 1);

    // Same-cycle issue and write to busy r9: data lands, busy stays, count steady.
    do_issue(9);
    iss_valid = 1'b1; iss_rd = AW'(9);
    we3 = 1'b1; wa3 = AW'(9); wd3 = 32'hA5A5A5A5;
    clock_edge();
    ra1 = AW'(9); sample("same9");
    check("same9.rd1", rd1, 32'hA5A5A5A5);
    check("same9.busy1", busy1, 1);
    check("same9.cnt", pend_cnt, 2);

    // Write to a non-busy register leaves busy and count alone.
    do_write(12, 32'hCAFE);
    ra1 = AW'(12); sample("nonbusy12");
    check("nonbusy12.cnt", pend_cnt, 2);

    // Duplicate issue to busy r7.
    do_issue(7);
    ra1 = AW'(7); sample("dup7");
    check("dup7.cnt", pend_cnt, 2);

    // Forwarding window: r4 busy, write presented but edge not yet taken.
    do_issue(4);
    we3 = 1'b1; wa3 = AW'(4); wd3 = 32'h55AA; ra1 = AW'(4);
    sample("byp4");
`ifdef REGFILE_BYPASS_EN
    check("byp4.rd1", rd1, 32'h55AA);
    check("byp4.busy1", busy1, 0);
`else
    check("byp4.rd1", rd1, 0);
    check("byp4.busy1", busy1, 1);
`endif
    clock_edge();
    sample("after4");
    check("after4.rd1", rd1, 32'h55AA);
    check("after4.busy1", busy1, 0);

    // Reset in the middle of an issue stream with a write pending.
    for (int i = 1; i < 16; i++) do_issue(i);
    reset = 1'b1; we3 = 1'b1; wa3 = AW'(10); wd3 = 32'hFFFF_0000;
    iss_valid = 1'b1; iss_rd = AW'(20);
    clock_edge();
    ra1 = AW'(10); ra2 = AW'(20); sample("mid_reset");
    check("mid_reset.cnt", pend_cnt, 0);
    check("mid_reset.rd1", rd1, 0);
    check("mid_reset.busy2", busy2, 0);
    for (int i = 1; i < NREGS; i++) do_issue(i);
    ra1 = AW'(1); ra2 = AW'(NREGS-1); sample("all_busy");
    check("all_busy.cnt", pend_cnt, 31);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      we3 = 1'($urandom_range(0, 1)); wa3 = AW'($urandom_range(0, NREGS-1)); wd3 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, NREGS-1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, NREGS-1));
      ra2 = AW'($urandom_range(0, NREGS-1));
      sample("rand");
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
